// File: rtl/ysyx_22040632_axi_burst_master_pkg.sv
// Shared constants for the dcache-side AXI4 burst master: request kinds, AXI field codes, FSM states.
package ysyx_22040632_axi_burst_master_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 3'd0;
    localparam fsm_state_t ST_AR   = 3'd1;
    localparam fsm_state_t ST_R    = 3'd2;
    localparam fsm_state_t ST_AW   = 3'd3;
    localparam fsm_state_t ST_W    = 3'd4;
    localparam fsm_state_t ST_B    = 3'd5;
    localparam fsm_state_t ST_DONE = 3'd6;

endpackage

// File: rtl/ysyx_22040632_axi_burst_master.sv
// AXI4 burst master behind the dcache: one outstanding AR/R or AW/W/B transaction at a time.
// Define YSYX_22040632_AXI_RESP_CHECK_EN for a sticky axi_err on non-OKAY responses plus sim assertions.
module ysyx_22040632_axi_burst_master
    import ysyx_22040632_axi_burst_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rrst_n,
    input  logic                  rw_valid,
    input  logic                  rw_req,
    input  logic [ADDR_W-1:0]     rw_addr,
    input  logic [2:0]            rw_size,
    input  logic [LEN_W-1:0]      rw_len,
    input  logic [DATA_W-1:0]     rw_w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_last,
    output logic                  rw_ready,
    output logic [DATA_W-1:0]     data_read,
    output logic                  r_hs,
    output logic                  r_last,
    output logic                  w_hs,
    output logic                  axi_write_ahead,
    output logic                  axi_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [LEN_W-1:0]      awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [ID_W-1:0]       awid,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [LEN_W-1:0]      arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [ID_W-1:0]       arid,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    fsm_state_t              r_state;
    fsm_state_t              w_state_next;
    logic [ADDR_W-1:0]       r_addr;
    logic [LEN_W-1:0]        r_len;
    logic [2:0]              r_size;
    logic [DATA_W/8-1:0]     r_strb;
    logic [LEN_W-1:0]        r_beat_cnt;
    logic [DATA_W-1:0]       r_data_read;
    logic                    w_r_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_wlast;

    // Handshake-facing outputs decode straight from state so an async reset drops them at once.
    assign arvalid         = (r_state == ST_AR);
    assign rready          = (r_state == ST_R);
    assign awvalid         = (r_state == ST_AW);
    assign axi_write_ahead = (r_state == ST_AW);
    assign wvalid          = (r_state == ST_W);
    assign bready          = (r_state == ST_B);
    assign rw_ready        = (r_state == ST_DONE);

    assign w_r_hs  = rready && rvalid;
    assign w_w_hs  = wvalid && wready;
    assign w_b_hs  = bready && bvalid;
    assign w_wlast = (r_beat_cnt == r_len);

    assign r_hs      = w_r_hs;
    assign r_last    = w_r_hs && rlast;
    assign w_hs      = w_w_hs;
    assign data_read = r_data_read;

    assign araddr  = r_addr;
    assign arlen   = r_len;
    assign arsize  = r_size;
    assign arburst = AXI_BURST_INCR;
    assign arid    = '0;
    assign awaddr  = r_addr;
    assign awlen   = r_len;
    assign awsize  = r_size;
    assign awburst = AXI_BURST_INCR;
    assign awid    = '0;
    assign wdata   = rw_w_data;
    assign wstrb   = r_strb;
    assign wlast   = w_wlast;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (rw_valid) w_state_next = (rw_req == REQ_WRITE) ? ST_AW : ST_AR;
            ST_AR:   if (arready) w_state_next = ST_R;
            ST_R:    if (w_r_hs && rlast) w_state_next = ST_DONE;
            ST_AW:   if (awready) w_state_next = ST_W;
            ST_W:    if (w_w_hs && w_wlast) w_state_next = ST_B;
            ST_B:    if (bvalid) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_strb      <= '0;
            r_beat_cnt  <= '0;
            r_data_read <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && rw_valid) begin
                r_addr <= rw_addr;
                r_len  <= rw_len;
                r_size <= rw_size;
                r_strb <= w_strb;
            end
            if (r_state == ST_AW && awready) begin
                r_beat_cnt <= '0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_r_hs) begin
                r_data_read <= rdata;
            end
        end
    end

`ifdef YSYX_22040632_AXI_RESP_CHECK_EN
    logic r_axi_err;
    logic w_resp_bad;

    assign w_resp_bad = (w_r_hs && rresp != AXI_RESP_OKAY) || (w_b_hs && bresp != AXI_RESP_OKAY);
    assign axi_err    = r_axi_err;

    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_axi_err <= 1'b0;
        end else if (w_resp_bad) begin
            r_axi_err <= 1'b1;
        end
    end

    a_resp_okay: assert property (@(posedge clk) disable iff (!rrst_n) !w_resp_bad);
    a_wlast_match: assert property (@(posedge clk) disable iff (!rrst_n) w_w_hs |-> (w_last == w_wlast));
`else
    logic w_unused_resp;

    assign axi_err       = 1'b0;
    assign w_unused_resp = ^{rresp, bresp, w_last, w_b_hs};
`endif

endmodule
